// File: rtl/commit_trace_buffer_if.sv
// Trace stream link: 32-bit words with valid/ready handshake and an
// end-of-record marker. The buffer drives the master side.
interface commit_trace_buffer_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// Retired-instruction trace buffer: captures one record per i_log_trace pulse
// into a small FIFO and streams each record out as 6 or 10 32-bit words.
// Build option: define TRACE_BACKPRESSURE_EN when o_stall freezes the core, so a
// refused record is re-presented and nothing is counted as dropped. Without it,
// records arriving while full are lost and counted in o_drop_count.
module commit_trace_buffer #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_log_trace,
    input  logic [ADDR_WIDTH-1:0]    i_pc_log,
    input  logic [INSTR_WIDTH-1:0]   i_instruction_log,
    input  logic [DATA_WIDTH-1:0]    i_reg_val,
    input  logic [REG_ADDR_W-1:0]    i_rd_addr,
    input  logic                     i_reg_we,
    input  logic                     i_mem_access_log,
    input  logic                     i_mem_we_log,
    input  logic [ADDR_WIDTH-1:0]    i_mem_addr_log,
    input  logic [DATA_WIDTH-1:0]    i_mem_write_data_log,
    output logic                     o_stall,
    commit_trace_buffer_if.master    tx,
    output logic [15:0]              o_drop_count,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned LevelW = PtrW + 1;

    typedef struct packed {
        logic [7:0]  seq;
        logic        mem_we;
        logic        mem_access;
        logic        reg_we;
        logic [7:0]  rd;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] reg_val;
        logic [63:0] mem_addr;
        logic [63:0] mem_data;
    } entry_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSend  = 2'd1,
        StDrain = 2'd2
    } state_e;

    entry_t              mem_q [DEPTH];
    entry_t              entry_in;
    entry_t              head;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0]   count_q, count_d;
    logic [7:0]          seq_q, seq_d;
    logic [15:0]         drop_q, drop_d;
    logic                push_q, push_d;
    logic                full, push, pop, avail;

    state_e              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    entry_t              rec_q, rec_d;
    logic                tx_valid_q, tx_valid_d;
    logic [31:0]         tx_data_q, tx_data_d;
    logic                tx_last_q, tx_last_d;

    // Word i of the packet, header first, 64-bit fields low half first.
    function automatic logic [31:0] pkt_word(input entry_t e, input logic [3:0] i);
        logic [31:0] w;
        case (i)
            4'd0:    w = {8'hA5, e.seq, 5'b0, e.mem_we, e.mem_access, e.reg_we, e.rd};
            4'd1:    w = e.pc[31:0];
            4'd2:    w = e.pc[63:32];
            4'd3:    w = e.instr;
            4'd4:    w = e.reg_val[31:0];
            4'd5:    w = e.reg_val[63:32];
            4'd6:    w = e.mem_addr[31:0];
            4'd7:    w = e.mem_addr[63:32];
            4'd8:    w = e.mem_data[31:0];
            4'd9:    w = e.mem_data[63:32];
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic logic [3:0] last_idx(input entry_t e);
        return e.mem_access ? 4'd9 : 4'd5;
    endfunction

    // Capture the incoming record, zero-extended, with memory fields masked off
    // when no memory access retired.
    always_comb begin
        entry_in         = '0;
        entry_in.seq     = seq_q;
        entry_in.rd      = 8'(i_rd_addr);
        entry_in.reg_we  = i_reg_we;
        entry_in.pc      = 64'(i_pc_log);
        entry_in.instr   = 32'(i_instruction_log);
        entry_in.reg_val = 64'(i_reg_val);
        if (i_mem_access_log) begin
            entry_in.mem_access = 1'b1;
            entry_in.mem_we     = i_mem_we_log;
            entry_in.mem_addr   = 64'(i_mem_addr_log);
            entry_in.mem_data   = 64'(i_mem_write_data_log);
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign full = (count_q == LevelW'(DEPTH));
    assign push = i_log_trace && !full;
    // An entry written on the previous edge is not read yet; this sets the
    // two-edge accept-to-valid latency while back-to-back records still flow.
    assign avail = (count_q > LevelW'(1)) || ((count_q == LevelW'(1)) && !push_q);

    // FIFO pointers, occupancy, sequence number and overflow counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        seq_d    = seq_q;
        push_d   = push;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            seq_d    = seq_q + 8'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + LevelW'(1);
            2'b01:   count_d = count_q - LevelW'(1);
            default: count_d = count_q;
        endcase
`ifdef TRACE_BACKPRESSURE_EN
        drop_d = '0;
`else
        drop_d = drop_q;
        if (i_log_trace && full && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
`endif
    end

    // Sender FSM: IDLE loads the head straight into the output register,
    // SEND walks the word index on each handshake and pops after the last word.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rec_d      = rec_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_last_d  = tx_last_q;
        pop        = 1'b0;
        case (state_q)
            StIdle: begin
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
                if (avail) begin
                    rec_d      = head;
                    idx_d      = 4'd0;
                    tx_data_d  = pkt_word(head, 4'd0);
                    tx_valid_d = 1'b1;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (tx_valid_q && tx.tx_ready) begin
                    if (tx_last_q) begin
                        pop        = 1'b1;
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = pkt_word(rec_q, idx_d);
                        tx_last_d = (idx_d == last_idx(rec_q));
                    end
                end else if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = pkt_word(rec_q, idx_q);
                    tx_last_d  = (idx_q == last_idx(rec_q));
                end
            end
            default: begin
                state_d    = StIdle;
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
            end
        endcase
    end

    // Entry storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
            push_q     <= 1'b0;
            state_q    <= StIdle;
            idx_q      <= '0;
            rec_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_last_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            push_q     <= push_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            rec_q      <= rec_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign tx.tx_data   = tx_data_q;
    assign tx.tx_valid  = tx_valid_q;
    assign tx.tx_last   = tx_last_q;
    assign o_stall      = full;
    assign o_level      = count_q;
    assign o_drop_count = drop_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: random and directed records, a queue-based
// packet model feeding a scoreboard, and a negedge monitor checking the stream.
module tb_commit_trace_buffer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        log_trace = 1'b0;
    logic [63:0] pc_i = '0;
    logic [31:0] instr_i = '0;
    logic [63:0] val_i = '0;
    logic [4:0]  rd_i = '0;
    logic        we_i = 1'b0;
    logic        ma_i = 1'b0;
    logic        mwe_i = 1'b0;
    logic [63:0] maddr_i = '0;
    logic [63:0] mdata_i = '0;
    logic        ready = 1'b0;
    logic        stall;
    logic [15:0] drop;
    logic [3:0]  level;

    always #5 clk = ~clk;

    commit_trace_buffer_if tx_if ();
    assign tx_if.tx_ready = ready;

    commit_trace_buffer #(
        .ADDR_WIDTH  (64),
        .DATA_WIDTH  (64),
        .INSTR_WIDTH (32),
        .REG_ADDR_W  (5),
        .DEPTH       (DEPTH)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_log_trace          (log_trace),
        .i_pc_log             (pc_i),
        .i_instruction_log    (instr_i),
        .i_reg_val            (val_i),
        .i_rd_addr            (rd_i),
        .i_reg_we             (we_i),
        .i_mem_access_log     (ma_i),
        .i_mem_we_log         (mwe_i),
        .i_mem_addr_log       (maddr_i),
        .i_mem_write_data_log (mdata_i),
        .o_stall              (stall),
        .tx                   (tx_if.master),
        .o_drop_count         (drop),
        .o_level              (level)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] val;
        logic [4:0]  rd;
        logic        we;
        logic        ma;
        logic        mwe;
        logic [63:0] maddr;
        logic [63:0] mdata;
    } rec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          acc_n = 0;
    int          done_n = 0;
    int          pend_acc = 0;
    int          drops = 0;
    int          pend_drop = 0;
    logic [7:0]  seq_m = 8'd0;
    logic [7:0]  last_seq = 8'hFF;
    bit          gap_arm = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t rnd_rec();
        rec_t r;
        r.pc    = {$urandom, $urandom};
        r.instr = $urandom;
        r.val   = {$urandom, $urandom};
        r.rd    = 5'($urandom_range(0, 31));
        r.we    = 1'($urandom_range(0, 1));
        r.ma    = 1'($urandom_range(0, 1));
        r.mwe   = 1'($urandom_range(0, 1));
        r.maddr = {$urandom, $urandom};
        r.mdata = {$urandom, $urandom};
        return r;
    endfunction

    // Expected packet built from the field list; absent memory fields read as zero.
    task automatic expect_record(input rec_t r, input logic [7:0] s);
        logic [31:0] w[$];
        logic        mwe;
        word_t       e;
        mwe = r.ma & r.mwe;
        w.push_back({8'hA5, s, 5'b0, mwe, r.ma, r.we, 3'b0, r.rd});
        w.push_back(r.pc[31:0]);
        w.push_back(r.pc[63:32]);
        w.push_back(r.instr);
        w.push_back(r.val[31:0]);
        w.push_back(r.val[63:32]);
        if (r.ma) begin
            w.push_back(r.maddr[31:0]);
            w.push_back(r.maddr[63:32]);
            w.push_back(r.mdata[31:0]);
            w.push_back(r.mdata[63:32]);
        end
        for (int i = 0; i < w.size(); i++) begin
            e.data = w[i];
            e.last = (i == w.size() - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: inputs change 1 time unit after the edge and the model decides
    // what the next edge will do with them.
    task automatic cycle(input logic push, input logic rdy, input logic rst_v, input rec_t r);
        @(posedge clk);
        #1;
        acc_n     += pend_acc;
        drops     += pend_drop;
        pend_acc  = 0;
        pend_drop = 0;
        rst       = rst_v;
        ready     = rdy;
        log_trace = push;
        pc_i      = r.pc;
        instr_i   = r.instr;
        val_i     = r.val;
        rd_i      = r.rd;
        we_i      = r.we;
        ma_i      = r.ma;
        mwe_i     = r.mwe;
        maddr_i   = r.maddr;
        mdata_i   = r.mdata;
        if (rst_v) begin
            exp_q.delete();
            acc_n  = 0;
            done_n = 0;
            drops  = 0;
            seq_m  = 8'd0;
        end else if (push) begin
            if (acc_n - done_n < int'(DEPTH)) begin
                expect_record(r, seq_m);
                seq_m    = seq_m + 8'd1;
                pend_acc = 1;
            end else begin
`ifndef TRACE_BACKPRESSURE_EN
                if (drops < 65535) pend_drop = 1;
`endif
            end
        end
    endtask

    task automatic drain(input int budget, input bit toggle);
        int   n;
        logic r;
        n = 0;
        r = 1'b1;
        while ((exp_q.size() != 0 || tx_if.tx_valid) && n < budget) begin
            if (toggle) r = ~r;
            cycle(1'b0, r, 1'b0, rnd_rec());
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || tx_if.tx_valid) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d words left required=0", exp_q.size());
        end
    endtask

    // Monitor: occupancy/flag tracking, hold-under-backpressure and word scoreboard.
    bit          held = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    bit          at_hdr = 1'b1;
    bit          gap_run = 1'b0;
    int          gap_n = 0;

    always @(negedge clk) begin
        word_t w;
        int    exp_drop;
        if (rst) begin
            held    = 1'b0;
            at_hdr  = 1'b1;
            gap_run = 1'b0;
        end else begin
`ifdef TRACE_BACKPRESSURE_EN
            exp_drop = 0;
`else
            exp_drop = drops;
`endif
            check("level", 64'(level), 64'(acc_n - done_n));
            check("stall", 64'(stall), 64'((acc_n - done_n) == int'(DEPTH)));
            check("drop_count", 64'(drop), 64'(exp_drop));
            if (held) begin
                check("hold_valid", 64'(tx_if.tx_valid), 64'd1);
                if (tx_if.tx_valid) begin
                    check("hold_data", 64'(tx_if.tx_data), 64'(held_data));
                    check("hold_last", 64'(tx_if.tx_last), 64'(held_last));
                end
            end
            if (gap_run) begin
                if (!tx_if.tx_valid) begin
                    gap_n++;
                end else begin
                    check("idle_gap", 64'(gap_n), 64'd1);
                    gap_run = 1'b0;
                    gap_arm = 1'b0;
                end
            end
            if (tx_if.tx_valid && ready) begin
                held = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%0h required=none", tx_if.tx_data);
                end else begin
                    w = exp_q.pop_front();
                    check("word", 64'(tx_if.tx_data), 64'(w.data));
                    check("last", 64'(tx_if.tx_last), 64'(w.last));
                    if (at_hdr) last_seq = tx_if.tx_data[23:16];
                    at_hdr = w.last;
                    if (w.last) begin
                        done_n++;
                        if (gap_arm && exp_q.size() != 0) begin
                            gap_run = 1'b1;
                            gap_n   = 0;
                        end
                    end
                end
            end else begin
                held      = tx_if.tx_valid;
                held_data = tx_if.tx_data;
                held_last = tx_if.tx_last;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t rec1, st;
        int   lat, n;

        rec1       = rnd_rec();
        rec1.pc    = 64'h8000_0004;
        rec1.instr = 32'h00A5_0513;
        rec1.rd    = 5'd10;
        rec1.we    = 1'b1;
        rec1.val   = 64'h1_0000_0002;
        rec1.ma    = 1'b0;

        st       = rnd_rec();
        st.ma    = 1'b1;
        st.mwe   = 1'b1;
        st.maddr = 64'h8000_1000;
        st.mdata = 64'hDEAD_BEEF;

        // Reset values
        cycle(1'b0, 1'b0, 1'b1, rnd_rec());
        cycle(1'b0, 1'b0, 1'b1, rnd_rec());
        cycle(1'b0, 1'b0, 1'b0, rnd_rec());
        check("rst_valid", 64'(tx_if.tx_valid), 64'd0);
        check("rst_data", 64'(tx_if.tx_data), 64'd0);
        check("rst_last", 64'(tx_if.tx_last), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        check("rst_level", 64'(level), 64'd0);

        // Single non-memory record: valid first seen two edges after accept
        cycle(1'b1, 1'b1, 1'b0, rec1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b1, 1'b0, rnd_rec());
            if (tx_if.tx_valid) begin
                lat = i;
                break;
            end
        end
        check("first_valid_latency", 64'(lat), 64'd3);
        drain(100, 1'b0);

        // Store record followed back-to-back by another: one idle cycle between
        gap_arm = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, st);
        cycle(1'b1, 1'b1, 1'b0, rec1);
        drain(100, 1'b0);
        check("gap_observed", 64'(gap_arm), 64'd0);

        // Backpressure: ready toggles every cycle, seq 0,1,2 after reset
        cycle(1'b0, 1'b0, 1'b1, rnd_rec());
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'(i % 2), 1'b0, rnd_rec());
        drain(300, 1'b1);
        check("bp_last_seq", 64'(last_seq), 64'd2);

        // Overflow with the sink stalled
        cycle(1'b0, 1'b0, 1'b1, rnd_rec());
        for (int i = 0; i < int'(DEPTH) + 3; i++) cycle(1'b1, 1'b0, 1'b0, rnd_rec());
        cycle(1'b0, 1'b0, 1'b0, rnd_rec());
        check("ovf_stall", 64'(stall), 64'd1);
        check("ovf_level", 64'(level), 64'(DEPTH));
`ifdef TRACE_BACKPRESSURE_EN
        check("ovf_drop", 64'(drop), 64'd0);
`else
        check("ovf_drop", 64'(drop), 64'd3);
`endif
        drain(300, 1'b0);
        check("ovf_last_seq", 64'(last_seq), 64'(DEPTH - 1));

        // Reset while W3 of a store record is on the link
        cycle(1'b1, 1'b1, 1'b0, st);
        n = 0;
        while (!tx_if.tx_valid && n < 10) begin
            cycle(1'b0, 1'b1, 1'b0, rnd_rec());
            n++;
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, rnd_rec());
        check("w3_before_reset", 64'(tx_if.tx_data), 64'(st.instr));
        cycle(1'b1, 1'b1, 1'b1, rnd_rec());
        cycle(1'b0, 1'b1, 1'b0, rnd_rec());
        check("mid_rst_valid", 64'(tx_if.tx_valid), 64'd0);
        check("mid_rst_level", 64'(level), 64'd0);
        cycle(1'b1, 1'b1, 1'b0, rec1);
        drain(100, 1'b0);
        check("seq_after_reset", 64'(last_seq), 64'd0);

        // Sequence wrap: 257 accepted records, last carries seq 0
        cycle(1'b0, 1'b0, 1'b1, rnd_rec());
        n = 0;
        while (acc_n + pend_acc < 257 && n < 20000) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0, rnd_rec());
            n++;
        end
        drain(3000, 1'b0);
        check("wrap_last_seq", 64'(last_seq), 64'd0);

        // Random mix with frequent overflow
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), 1'b0, rnd_rec());
        end
        drain(3000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Hardware consumer of the write-back stage's retired-instruction trace record. It captures one record per `i_log_trace` pulse into a small FIFO and streams each record out as 32-bit words over a valid/ready link toward an off-core trace port. It sits beside the write-back stage and lets simulation-only trace logging be replaced by a synthesizable path usable on FPGA.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: PC and memory address width; must be ≤ 64, zero-extended to 64 in the packet.
- `DATA_WIDTH`, 64: register and memory data width; must be ≤ 64, zero-extended to 64.
- `INSTR_WIDTH`, 32: instruction width; must be 32.
- `REG_ADDR_W`, 5: destination register address width; must be ≤ 8.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.

Ports:
- `i_clk`, input, 1: clock. Single clock domain.
- `i_rst`, input, 1: reset, synchronous and active-high.
- `i_log_trace`, input, 1: record valid, one cycle per retired instruction.
- `i_pc_log`, input, ADDR_WIDTH: retired PC.
- `i_instruction_log`, input, INSTR_WIDTH: retired instruction.
- `i_reg_val`, input, DATA_WIDTH: write-back result.
- `i_rd_addr`, input, REG_ADDR_W: destination register.
- `i_reg_we`, input, 1: register written.
- `i_mem_access_log`, input, 1: load or store retired.
- `i_mem_we_log`, input, 1: store.
- `i_mem_addr_log`, input, ADDR_WIDTH: memory address.
- `i_mem_write_data_log`, input, DATA_WIDTH: memory data.
- `o_stall`, output, 1: FIFO full.
- `o_tx_data`, output, 32: stream word.
- `o_tx_valid`, output, 1: word valid.
- `o_tx_last`, output, 1: last word of the record.
- `i_tx_ready`, input, 1: sink accepts the word.
- `o_drop_count`, output, 16: records lost to overflow, saturating.
- `o_level`, output, $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Push condition: `i_log_trace && count < DEPTH`. A push is refused when `count == DEPTH`, even if a pop happens in the same cycle. A pop in the same cycle as a push is allowed when not full.
- Sequence counter: 8 bits, increments on each accepted push, wraps 255→0. The value is stored with the entry.
- Packet format, with words sent LSW first:
  - W0 header: [31:24] = 0xA5; [23:16] = seq; [15:11] = 0; [10] = mem_we; [9] = mem_access; [8] = reg_we; [7:0] = rd_addr, zero-extended.
  - W1/W2: PC lo/hi.
  - W3: instruction.
  - W4/W5: reg_val lo/hi.
  - If mem_access: W6/W7 = mem_addr lo/hi, then W8/W9 = mem data lo/hi.
  - Record length is 6 words, or 10 words when mem_access = 1. `o_tx_last` is asserted on W5 or W9 respectively.
- `mem_we`, `mem_addr` and mem data are forced to 0 in the stored entry when `i_mem_access_log = 0`.
- FSM states:
  - IDLE: if the FIFO is non-empty, load the head into the output register, set word index to 0, go to SEND.
  - SEND: `o_tx_valid = 1`. On `o_tx_valid && i_tx_ready`: if `o_tx_last`, pop the FIFO and go to IDLE; otherwise increment the word index.
  - DRAIN: reserved; unused encoding returns to IDLE.
- `o_tx_data`, `o_tx_last` and `o_tx_valid` are registered. Data and last hold stable while `o_tx_valid && !i_tx_ready`.
- `o_level` equals count. `o_stall = (count == DEPTH)`.

## Timing
- Reset values: `o_tx_valid = 0`, `o_tx_data = 0`, `o_tx_last = 0`, `o_stall = 0`, `o_drop_count = 0`, `o_level = 0`. On reset the FIFO is empty, seq = 0 and the FSM is in IDLE.
- Latency: a record accepted at edge E with an empty FIFO and the FSM in IDLE gives `o_tx_valid` high after edge E+2.
- Throughput: one word per cycle while `i_tx_ready` is held high. There is exactly one idle cycle (`o_tx_valid = 0`) between consecutive records.
- `o_level` and `o_stall` update on the edge after a push or pop.
- The popped entry is freed on the edge that accepts the last word.
- Reset mid-record: the partial record is discarded and `o_tx_valid` is low in the cycle after the reset edge. No resume.
- `i_log_trace` during reset is ignored.

## Configuration
- `TRACE_BACKPRESSURE_EN` defined:
  - `o_stall` is meant to freeze the core pipeline.
  - A record presented while full is not captured. The producer holds and re-presents it.
  - `o_drop_count` is tied to 0.
- `TRACE_BACKPRESSURE_EN` undefined:
  - `o_stall` is informational only.
  - A record presented while full is dropped, `o_drop_count` increments (saturating at 0xFFFF), and seq does not advance.

## Test plan
- Single non-memory record: PC = 0x8000_0004, instruction = 0x00A5_0513, rd = 10, reg_we = 1, value = 0x1_0000_0002, `i_tx_ready` = 1 → 6 words: 0xA500_010A, 0x8000_0004, 0x0, 0x00A5_0513, 0x2, 0x1, with `o_tx_last` on word 6 and valid first seen 2 cycles after accept.
- Store record with mem_addr = 0x8000_1000 and data = 0xDEAD_BEEF → 10 words, header bits [10:9] = 2'b11, W6 = 0x8000_1000, W8 = 0xDEAD_BEEF.
- Backpressure: toggle `i_tx_ready` every cycle → each word is held until a handshake, no word is duplicated or skipped, and seq fields run 0, 1, 2.
- Overflow, with `i_tx_ready` = 0 and DEPTH + 3 consecutive pushes:
  - Macro undefined: `o_stall` = 1 after DEPTH pushes, `o_drop_count` = 3, and the seq values sent are 0..DEPTH−1.
  - Macro defined: `o_drop_count` stays 0.
- Seq wrap: 257 records → seq of the last record = 0x00.
- Reset asserted during W3 of a record → `o_tx_valid` = 0 and `o_level` = 0 next cycle. The next record sent has seq = 0.
